// File: rtl/backlight_frame_writer.sv
// rtl/backlight_frame_writer.sv - per-frame zone-dimmed LED grey value generator for the SRAM frame writer
module backlight_frame_writer #(
    parameter int ROWS         = 12,
    parameter int COLS         = 12,
    parameter int FRAME_CYC    = 416667,
    parameter int CHASE_FRAMES = 30
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [71:0] light_reg,
    input  logic [1:0]  mode_sel,
    output logic        sdbpflag,
    output logic        wt_en,
    output logic [9:0]  wtaddr,
    output logic [15:0] wtdina,
    output logic        busy,
    output logic        overrun
);

    localparam int NLED = ROWS * COLS;
    localparam int ZR   = ROWS / 3;
    localparam int ZC   = COLS / 3;
    localparam int TW   = $clog2(FRAME_CYC + 1);
    localparam int CW   = $clog2(CHASE_FRAMES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SOF   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [8:0]    r_breath;
    logic [CW-1:0] r_chase_cnt;
    logic [3:0]    r_chase_idx;
    logic [71:0]   r_sh_light;
    logic [1:0]    r_sh_mode;

    logic [9:0]    r_addr;
    logic [9:0]    r_zc_cnt;
    logic [9:0]    r_zr_cnt;
    logic [1:0]    r_zcol;
    logic [1:0]    r_zrow;

    logic          r_sdbpflag;
    logic          r_wt_en;
    logic [9:0]    r_wtaddr;
    logic [15:0]   r_wtdina;
    logic          r_busy;
    logic          r_overrun;

    logic [3:0]    w_zone;
    logic [7:0]    w_level;
    logic [7:0]    w_phase;
    logic [7:0]    w_le_breath;
    logic [7:0]    w_le;
    logic [15:0]   w_square;
    logic [15:0]   w_grey;
    logic          w_expire;
    logic          w_last;
    logic [CW-1:0] w_chase_nxt;

    // Zone index comes from the boundary counters, so no divider is needed.
    always_comb begin
        w_zone      = ({2'b00, r_zrow} << 1) + {2'b00, r_zrow} + {2'b00, r_zcol};
        w_level     = r_sh_light[{w_zone, 3'b000} +: 8];
        w_phase     = r_breath[8] ? ~r_breath[7:0] : r_breath[7:0];
        w_le_breath = 8'(({8'd0, w_level} * {8'd0, w_phase}) >> 8);
        w_le        = w_level;
        case (r_sh_mode)
            2'd1:    w_le = w_le_breath;
            2'd2:    w_le = (w_zone == r_chase_idx) ? w_level : 8'd0;
            default: w_le = w_level;
        endcase
        w_square    = {8'd0, w_le} * {8'd0, w_le};
        w_grey      = (r_sh_mode == 2'd3) ? 16'hFFFF : w_square;
        w_expire    = (r_timer <= TW'(1));
        w_last      = (r_addr == 10'(NLED - 1));
        w_chase_nxt = r_chase_cnt + CW'(1);
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_breath    <= '0;
            r_chase_cnt <= '0;
            r_chase_idx <= '0;
            r_sh_light  <= '0;
            r_sh_mode   <= '0;
            r_addr      <= '0;
            r_zc_cnt    <= '0;
            r_zr_cnt    <= '0;
            r_zcol      <= '0;
            r_zrow      <= '0;
            r_sdbpflag  <= 1'b0;
            r_wt_en     <= 1'b0;
            r_wtaddr    <= '0;
            r_wtdina    <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sdbpflag <= (r_state == S_SOF);
            r_busy     <= (r_state == S_SOF) || (r_state == S_WRITE);
            r_wt_en    <= (r_state == S_WRITE);

            // Timer saturates at zero so a late frame still sees it expired.
            if (r_state != S_IDLE && r_timer != '0) begin
                r_timer <= r_timer - TW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_SOF;
                end
                S_SOF: begin
                    r_sh_light <= light_reg;
                    r_sh_mode  <= mode_sel;
                    r_timer    <= TW'(FRAME_CYC - 1);
                    r_breath   <= r_breath + 9'd1;
                    if (w_chase_nxt == CW'(CHASE_FRAMES)) begin
                        r_chase_cnt <= '0;
                        r_chase_idx <= (r_chase_idx == 4'd8) ? 4'd0 : r_chase_idx + 4'd1;
                    end else begin
                        r_chase_cnt <= w_chase_nxt;
                    end
                    r_addr   <= '0;
                    r_zc_cnt <= '0;
                    r_zr_cnt <= '0;
                    r_zcol   <= '0;
                    r_zrow   <= '0;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_wtaddr <= r_addr;
                    r_wtdina <= w_grey;
                    r_addr   <= r_addr + 10'd1;
                    if (r_zc_cnt == 10'(ZC - 1)) begin
                        r_zc_cnt <= '0;
                        if (r_zcol == 2'd2) begin
                            r_zcol <= '0;
                            if (r_zr_cnt == 10'(ZR - 1)) begin
                                r_zr_cnt <= '0;
                                r_zrow   <= r_zrow + 2'd1;
                            end else begin
                                r_zr_cnt <= r_zr_cnt + 10'd1;
                            end
                        end else begin
                            r_zcol <= r_zcol + 2'd1;
                        end
                    end else begin
                        r_zc_cnt <= r_zc_cnt + 10'd1;
                    end
                    if (w_last) begin
                        r_state <= w_expire ? S_SOF : S_WAIT;
                    end else if (w_expire) begin
                        r_overrun <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_expire) begin
                        r_state <= S_SOF;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sdbpflag = r_sdbpflag;
    assign wt_en    = r_wt_en;
    assign wtaddr   = r_wtaddr;
    assign wtdina   = r_wtdina;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_backlight_frame_writer.sv
// tb/tb_backlight_frame_writer.sv - self-checking bench for backlight_frame_writer
module tb_backlight_frame_writer;

    localparam int CF = 1;
    localparam logic [71:0] TABLE_A = {8'd128, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd16, 8'd255};

    logic        clk;
    logic        rst_n;
    logic [71:0] light_reg;
    logic [1:0]  mode_sel;
    logic [1:0]  sdb;
    logic [1:0]  wten;
    logic [1:0]  bsy;
    logic [1:0]  ovr;
    logic [9:0]  addr [2];
    logic [15:0] data [2];

    int checks = 0;
    int errors = 0;
    int fc [2] = '{200, 100};

    int          m_t [2];
    int          m_next [2];
    int          m_cur [2];
    int          m_breath [2];
    int          m_ccnt [2];
    int          m_cidx [2];
    logic [71:0] m_light [2];
    logic [1:0]  m_mode [2];
    int          m_ovr [2];

    int          o_frames [2];
    int          o_first [2];
    int          o_last [2];
    int          o_gap [2];
    int          o_en_cnt [2];
    int          o_en_done [2];
    logic [15:0] cap0 [0:1023];
    logic        s_rst;

    backlight_frame_writer #(.ROWS(12), .COLS(12), .FRAME_CYC(200), .CHASE_FRAMES(CF)) u_dut0 (
        .I_clk(clk), .I_rst_n(rst_n), .light_reg(light_reg), .mode_sel(mode_sel),
        .sdbpflag(sdb[0]), .wt_en(wten[0]), .wtaddr(addr[0]), .wtdina(data[0]),
        .busy(bsy[0]), .overrun(ovr[0])
    );

    backlight_frame_writer #(.ROWS(12), .COLS(12), .FRAME_CYC(100), .CHASE_FRAMES(CF)) u_dut1 (
        .I_clk(clk), .I_rst_n(rst_n), .light_reg(light_reg), .mode_sel(mode_sel),
        .sdbpflag(sdb[1]), .wt_en(wten[1]), .wtaddr(addr[1]), .wtdina(data[1]),
        .busy(bsy[1]), .overrun(ovr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int period(input int f);
        return (f >= 145) ? f : 145;
    endfunction

    function automatic int grey(input logic [71:0] lt, input logic [1:0] md,
                                input int br, input int ci, input int a);
        int row, col, z, lv, ph, le;
        row = a / 12;
        col = a % 12;
        z   = (row / 4) * 3 + col / 4;
        lv  = int'(lt[z*8 +: 8]);
        case (md)
            2'd0: le = lv;
            2'd1: begin
                ph = (br >= 256) ? 511 - br : br;
                le = (lv * ph) / 256;
            end
            2'd2: le = (z == ci) ? lv : 0;
            default: return 65535;
        endcase
        return le * le;
    endfunction

    task automatic cchk(input int i, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL u%0d t=%0d %s: got %0d expected %0d", i, m_t[i], name, act, exp);
        end
    endtask

    task automatic lchk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int i);
        if (!s_rst) begin
            m_t[i] = 0; m_next[i] = 2; m_cur[i] = -1; m_breath[i] = 0;
            m_ccnt[i] = 0; m_cidx[i] = 0; m_ovr[i] = 0; m_light[i] = '0; m_mode[i] = '0;
        end else begin
            m_t[i]++;
            if (m_t[i] == m_next[i]) begin
                m_cur[i]    = m_t[i];
                m_next[i]   = m_next[i] + period(fc[i]);
                m_light[i]  = light_reg;
                m_mode[i]   = mode_sel;
                m_breath[i] = (m_breath[i] + 1) % 512;
                m_ccnt[i]++;
                if (m_ccnt[i] == CF) begin
                    m_ccnt[i] = 0;
                    m_cidx[i] = (m_cidx[i] + 1) % 9;
                end
            end
            if (m_cur[i] >= 0 && fc[i] <= 144 && m_t[i] == m_cur[i] + fc[i] - 1) m_ovr[i] = 1;
        end
    endtask

    task automatic compare(input int i);
        int off;
        int e_en;
        if (m_t[i] <= 1) begin
            cchk(i, "sdbpflag", int'(sdb[i]), 0);
            cchk(i, "wt_en", int'(wten[i]), 0);
            cchk(i, "busy", int'(bsy[i]), 0);
            cchk(i, "overrun", int'(ovr[i]), 0);
            cchk(i, "wtaddr", int'(addr[i]), 0);
            cchk(i, "wtdina", int'(data[i]), 0);
        end else begin
            off  = m_t[i] - m_cur[i];
            e_en = (off >= 1 && off <= 144) ? 1 : 0;
            cchk(i, "sdbpflag", int'(sdb[i]), (off == 0) ? 1 : 0);
            cchk(i, "wt_en", int'(wten[i]), e_en);
            cchk(i, "busy", int'(bsy[i]), (off <= 144) ? 1 : 0);
            cchk(i, "overrun", int'(ovr[i]), m_ovr[i]);
            if (e_en == 1) begin
                cchk(i, "wtaddr", int'(addr[i]), off - 1);
                cchk(i, "wtdina", int'(data[i]),
                     grey(m_light[i], m_mode[i], m_breath[i], m_cidx[i], off - 1));
            end
        end
    endtask

    task automatic observe(input int i);
        if (!s_rst) begin
            o_frames[i] = 0; o_first[i] = 0; o_last[i] = 0; o_gap[i] = 0;
            o_en_cnt[i] = 0; o_en_done[i] = 0;
        end else begin
            if (sdb[i]) begin
                o_frames[i]++;
                if (o_frames[i] == 1) o_first[i] = m_t[i];
                else o_gap[i] = m_t[i] - o_last[i];
                o_last[i]    = m_t[i];
                o_en_done[i] = o_en_cnt[i];
                o_en_cnt[i]  = 0;
            end
            if (wten[i]) begin
                o_en_cnt[i]++;
                if (i == 0) cap0[addr[0]] = data[0];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            s_rst = rst_n;
            for (int i = 0; i < 2; i++) model_step(i);
            #1;
            for (int i = 0; i < 2; i++) begin
                compare(i);
                observe(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_frame(input int i, input int target);
        int budget;
        budget = 400 * (target - o_frames[i]) + 400;
        while (o_frames[i] < target && budget > 0) begin
            step();
            budget--;
        end
        if (o_frames[i] < target) lchk("sof_timeout", o_frames[i], target);
    endtask

    task automatic restart(input logic [71:0] lt, input logic [1:0] md);
        rst_n = 1'b0;
        step();
        step();
        light_reg = lt;
        mode_sel  = md;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        light_reg = TABLE_A;
        mode_sel  = 2'd0;
        repeat (5) step();
        rst_n = 1'b1;

        wait_frame(0, 2);
        lchk("first_sof_cycle", o_first[0], 2);
        lchk("wt_en_count", o_en_done[0], 144);
        lchk("sof_period", o_gap[0], 200);
        lchk("static_addr0", int'(cap0[0]), 65025);
        lchk("static_addr4", int'(cap0[4]), 256);
        lchk("static_addr48", int'(cap0[48]), 1);
        lchk("static_addr143", int'(cap0[143]), 16384);
        lchk("static_addr3", int'(cap0[3]), 65025);

        repeat (50) step();
        light_reg[7:0] = 8'd0;
        wait_frame(0, 3);
        lchk("shadow_same_frame", int'(cap0[0]), 65025);
        wait_frame(0, 4);
        lchk("shadow_next_frame", int'(cap0[0]), 0);
        lchk("u1_overrun", int'(ovr[1]), 1);
        lchk("u1_wt_en_count", o_en_done[1], 144);
        lchk("u1_sof_period", o_gap[1], 145);

        restart({72{1'b1}}, 2'd2);
        wait_frame(0, 2);
        lchk("chase_f1_zone1", int'(cap0[4]), 65025);
        lchk("chase_f1_zone0", int'(cap0[0]), 0);
        lchk("chase_f1_zone8", int'(cap0[143]), 0);
        wait_frame(0, 10);
        lchk("chase_wrap_zone0", int'(cap0[0]), 65025);
        lchk("chase_wrap_zone1", int'(cap0[4]), 0);

        restart({72{1'b1}}, 2'd1);
        wait_frame(0, 2);
        lchk("breath_f1", int'(cap0[0]), 0);
        wait_frame(0, 256);
        lchk("breath_f255", int'(cap0[77]), 64516);
        wait_frame(0, 257);
        lchk("breath_f256", int'(cap0[77]), 64516);
        wait_frame(0, 258);
        lchk("breath_f257", int'(cap0[77]), 64009);

        mode_sel = 2'd3;
        wait_frame(0, 260);
        lchk("test_mode_addr100", int'(cap0[100]), 65535);

        lchk("u1_overrun_sticky", int'(ovr[1]), 1);
        wait_frame(1, o_frames[1] + 1);
        repeat (20) step();
        lchk("u1_mid_write_en", int'(wten[1]), 1);
        rst_n = 1'b0;
        step();
        lchk("u1_reset_wt_en", int'(wten[1]), 0);
        lchk("u1_reset_overrun", int'(ovr[1]), 0);
        lchk("u1_reset_busy", int'(bsy[1]), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
